// File: rtl/eth_wb_slave_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : eth_wb_pkg
// Description : Shared Wishbone B3 constants, FSM state type and burst address
//               stepping for the ethmac system-memory slave.
// Revision    : 1.0  initial release
// ============================================================================
package eth_wb_pkg;

    // Cycle type identifiers (m_wb_cti_o)
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    // Burst type identifiers (m_wb_bte_o)
    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_ACK   = 2'd2,
        S_BURST = 2'd3
    } wb_state_e;

    // Next word address of a burst. Wrap modes keep the upper bits and
    // step only the low 2/3/4 bits modulo the wrap length.
    function automatic logic [31:0] wb_next_addr(input logic [31:0] addr,
                                                 input logic [1:0]  bte);
        logic [31:0] nxt;
        nxt = addr + 32'd1;
        case (bte)
            BTE_WRAP4:  nxt = {addr[31:2], addr[1:0] + 2'd1};
            BTE_WRAP8:  nxt = {addr[31:3], addr[2:0] + 3'd1};
            BTE_WRAP16: nxt = {addr[31:4], addr[3:0] + 4'd1};
            default:    nxt = addr + 32'd1;
        endcase
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/eth_wb_slave_mem_if.sv
`default_nettype none
// ============================================================================
// Module      : eth_wb_slave_mem_if
// Description : Wishbone B3 bus between the ethmac DMA master (m_wb_*) and
//               the system-memory slave. Signal names follow the master's
//               view (_o driven by master, _i driven by slave).
//   master modport : drives adr/sel/we/dat_o/cyc/stb/cti/bte
//   slave  modport : drives dat_i/ack/err/rty
// Revision    : 1.0  initial release
// ============================================================================
interface eth_wb_slave_mem_if;
    logic [31:0] m_wb_adr_o;
    logic [3:0]  m_wb_sel_o;
    logic        m_wb_we_o;
    logic [31:0] m_wb_dat_o;
    logic        m_wb_cyc_o;
    logic        m_wb_stb_o;
    logic [2:0]  m_wb_cti_o;
    logic [1:0]  m_wb_bte_o;
    logic [31:0] m_wb_dat_i;
    logic        m_wb_ack_i;
    logic        m_wb_err_i;
    logic        m_wb_rty_i;

    modport master (
        output m_wb_adr_o, m_wb_sel_o, m_wb_we_o, m_wb_dat_o,
               m_wb_cyc_o, m_wb_stb_o, m_wb_cti_o, m_wb_bte_o,
        input  m_wb_dat_i, m_wb_ack_i, m_wb_err_i, m_wb_rty_i
    );

    modport slave (
        input  m_wb_adr_o, m_wb_sel_o, m_wb_we_o, m_wb_dat_o,
               m_wb_cyc_o, m_wb_stb_o, m_wb_cti_o, m_wb_bte_o,
        output m_wb_dat_i, m_wb_ack_i, m_wb_err_i, m_wb_rty_i
    );
endinterface
`default_nettype wire

// File: rtl/eth_wb_slave_mem_ram.sv
`default_nettype none
// ============================================================================
// Module      : eth_wb_ram
// Description : Single-port, byte-enabled synchronous RAM, 2**AW x 32,
//               registered read (read-before-write on the same edge).
//   i_clk   : clock
//   i_we    : write enable, qualified per lane by i_be
//   i_be    : byte enables
//   i_addr  : word address
//   i_wdata : write data
//   o_rdata : read data, one cycle after i_addr
// Revision    : 1.0  initial release
// ============================================================================
module eth_wb_ram #(
    parameter int AW = 10
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [3:0]    i_be,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    localparam int c_depth = 1 << AW;

    logic [31:0] r_mem [0:c_depth-1];
    logic [31:0] r_rdata_q;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int i = 0; i < 4; i++) begin
                if (i_be[i]) begin
                    r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
                end
            end
        end
        r_rdata_q <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata_q;

endmodule
`default_nettype wire

// File: rtl/eth_wb_slave_mem.sv
`default_nettype none
// ============================================================================
// Module      : eth_wb_slave_mem
// Description : Wishbone B3 slave memory downstream of the ethmac DMA master.
//               Classic and incrementing-burst cycles, programmable wait
//               states before the first ack, error injection and an
//               out-of-window error response.
//   wb_clk_i / wb_rst_i : clock, synchronous active-high reset
//   wb                  : Wishbone bus (slave modport)
//   wait_cfg_i          : wait states before first ack (clamped to MAX_WAIT)
//   err_inject_i        : sampled at access start, forces an err response
//   acc_cnt_o           : count of acked beats, wraps at 16 bits
// Revision    : 1.0  initial release
// ============================================================================
module eth_wb_slave_mem
    import eth_wb_pkg::*;
#(
    parameter int          MEM_AW    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WAIT  = 15
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    eth_wb_slave_mem_if.slave wb,
    input  logic [3:0]        wait_cfg_i,
    input  logic              err_inject_i,
    output logic [15:0]       acc_cnt_o
);

    // Kept one bit wider than wait_cfg_i so the clamp compare is never trivial.
    localparam logic [4:0] c_max_wait = (MAX_WAIT >= 15) ? 5'd15 : 5'(MAX_WAIT);

    wb_state_e         r_state_q, w_state_d;
    logic [MEM_AW-1:0] r_addr_q,  w_addr_d;
    logic              r_we_q,    w_we_d;
    logic [2:0]        r_cti_q,   w_cti_d;
    logic [1:0]        r_bte_q,   w_bte_d;
    logic              r_err_q,   w_err_d;
    logic [3:0]        r_wcnt_q,  w_wcnt_d;
    logic [15:0]       r_acc_q,   w_acc_d;

    logic              w_req;
    logic [30:0]       w_off;
    logic              w_in_win;
    logic [MEM_AW-1:0] w_word;
    logic [3:0]        w_wait_ld;
    logic [31:0]       w_next_full;
    logic [MEM_AW-1:0] w_addr_next;
    logic              w_ack;
    logic              w_err;
    logic              w_ram_we;
    logic [MEM_AW-1:0] w_ram_addr;
    logic [31:0]       w_rdata;
    logic              w_unused;

    assign w_req = wb.m_wb_cyc_o & wb.m_wb_stb_o;

    // Word offset from the window base; the extra top bit catches addresses
    // below the base (borrow), so one zero-test covers both window edges.
    assign w_off    = {1'b0, wb.m_wb_adr_o[31:2]} - {1'b0, BASE_ADDR[31:2]};
    assign w_in_win = (w_off[30:MEM_AW] == '0);
    assign w_word   = w_off[MEM_AW-1:0];

    assign w_wait_ld = ({1'b0, wait_cfg_i} > c_max_wait) ? c_max_wait[3:0] : wait_cfg_i;

    assign w_next_full = wb_next_addr({{(32-MEM_AW){1'b0}}, r_addr_q}, r_bte_q);
    assign w_addr_next = w_next_full[MEM_AW-1:0];

    assign w_unused = ^{wb.m_wb_adr_o[1:0], w_next_full[31:MEM_AW]};

    always_comb begin
        w_state_d = r_state_q;
        w_addr_d  = r_addr_q;
        w_we_d    = r_we_q;
        w_cti_d   = r_cti_q;
        w_bte_d   = r_bte_q;
        w_err_d   = r_err_q;
        w_wcnt_d  = r_wcnt_q;
        w_ack     = 1'b0;
        w_err     = 1'b0;

        case (r_state_q)
            S_IDLE: begin
                if (w_req) begin
                    w_addr_d = w_word;
                    w_we_d   = wb.m_wb_we_o;
                    w_cti_d  = wb.m_wb_cti_o;
                    w_bte_d  = wb.m_wb_bte_o;
                    w_err_d  = err_inject_i | ~w_in_win;
                    if (w_wait_ld != 4'd0) begin
                        w_wcnt_d  = w_wait_ld;
                        w_state_d = S_WAIT;
                    end else begin
                        w_state_d = S_ACK;
                    end
                end
            end

            S_WAIT: begin
                if (!w_req) begin
                    w_state_d = S_IDLE;
                end else if (r_wcnt_q <= 4'd1) begin
                    w_state_d = S_ACK;
                end else begin
                    w_wcnt_d = r_wcnt_q - 4'd1;
                end
            end

            S_ACK: begin
                w_state_d = S_IDLE;
                if (w_req) begin
                    w_ack = ~r_err_q;
                    w_err = r_err_q;
                    if (!r_err_q && (r_cti_q == CTI_INCR)) begin
                        w_state_d = S_BURST;
                        w_addr_d  = w_addr_next;
                    end
                end
            end

            S_BURST: begin
                if (!wb.m_wb_cyc_o) begin
                    w_state_d = S_IDLE;
                end else if (wb.m_wb_stb_o) begin
                    w_ack = 1'b1;
                    if (wb.m_wb_cti_o == CTI_EOB) begin
                        w_state_d = S_IDLE;
                    end else begin
                        w_addr_d = w_addr_next;
                    end
                end
            end

            default: w_state_d = S_IDLE;
        endcase

        w_acc_d = w_ack ? (r_acc_q + 16'd1) : r_acc_q;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state_q <= S_IDLE;
            r_addr_q  <= '0;
            r_we_q    <= 1'b0;
            r_cti_q   <= CTI_CLASSIC;
            r_bte_q   <= BTE_LINEAR;
            r_err_q   <= 1'b0;
            r_wcnt_q  <= 4'd0;
            r_acc_q   <= 16'd0;
        end else begin
            r_state_q <= w_state_d;
            r_addr_q  <= w_addr_d;
            r_we_q    <= w_we_d;
            r_cti_q   <= w_cti_d;
            r_bte_q   <= w_bte_d;
            r_err_q   <= w_err_d;
            r_wcnt_q  <= w_wcnt_d;
            r_acc_q   <= w_acc_d;
        end
    end

    // Writes land at the ack edge on the current beat address. Otherwise the
    // RAM is read at the address the FSM holds next cycle, so read data is
    // ready in the following ack cycle (including the next burst beat).
    assign w_ram_we   = w_ack & r_we_q & ~wb_rst_i;
    assign w_ram_addr = w_ram_we ? r_addr_q : w_addr_d;

    eth_wb_ram #(
        .AW (MEM_AW)
    ) u_ram (
        .i_clk   (wb_clk_i),
        .i_we    (w_ram_we),
        .i_be    (wb.m_wb_sel_o),
        .i_addr  (w_ram_addr),
        .i_wdata (wb.m_wb_dat_o),
        .o_rdata (w_rdata)
    );

    assign wb.m_wb_ack_i = w_ack;
    assign wb.m_wb_err_i = w_err;
    assign wb.m_wb_rty_i = 1'b0;
    assign wb.m_wb_dat_i = (w_ack & ~r_we_q) ? w_rdata : 32'h0;
    assign acc_cnt_o     = r_acc_q;

endmodule
`default_nettype wire

// File: tb/tb_eth_wb_slave_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_eth_wb_slave_mem
// Description : Self-checking bench for eth_wb_slave_mem. Expected beat
//               results are queued when a transfer is driven and compared
//               as ack/err appears on the bus.
// Revision    : 1.0  initial release
// ============================================================================
module tb_eth_wb_slave_mem;
    import eth_wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  wait_cfg;
    logic        err_inject;
    logic [15:0] acc_cnt;

    eth_wb_slave_mem_if bus();

    eth_wb_slave_mem #(
        .MEM_AW    (10),
        .BASE_ADDR (32'h0000_0000),
        .MAX_WAIT  (15)
    ) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .wb           (bus.slave),
        .wait_cfg_i   (wait_cfg),
        .err_inject_i (err_inject),
        .acc_cnt_o    (acc_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    typedef struct {
        bit          is_err;
        bit          chk_data;
        logic [31:0] data;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] mem_m [0:1023];
    int          cyc_n = 0;

    always @(posedge clk) cyc_n++;

    // Scoreboard monitor: every ack/err beat consumes one expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && (bus.m_wb_ack_i || bus.m_wb_err_i)) begin
            check_eq("ack_err_excl", 32'(bus.m_wb_ack_i & bus.m_wb_err_i), 32'd0);
            check_eq("term_has_req", 32'(bus.m_wb_cyc_o & bus.m_wb_stb_o), 32'd1);
            if (sb_q.size() == 0) begin
                check_eq("unexpected_term", {30'd0, bus.m_wb_ack_i, bus.m_wb_err_i}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check_eq("term_kind", 32'(bus.m_wb_err_i), 32'(e.is_err));
                if (e.is_err || e.chk_data)
                    check_eq("rdata", bus.m_wb_dat_i, e.is_err ? 32'h0 : e.data);
            end
        end
    end

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (sel[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    task automatic bus_idle();
        bus.m_wb_cyc_o = 1'b0;
        bus.m_wb_stb_o = 1'b0;
        bus.m_wb_we_o  = 1'b0;
        bus.m_wb_sel_o = 4'h0;
        bus.m_wb_adr_o = 32'h0;
        bus.m_wb_dat_o = 32'h0;
        bus.m_wb_cti_o = CTI_CLASSIC;
        bus.m_wb_bte_o = BTE_LINEAR;
    endtask

    // Counts negedges until ack or err shows; bounded.
    task automatic wait_term(output int lat);
        bit ok;
        ok  = 1'b0;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.m_wb_ack_i || bus.m_wb_err_i) begin
                ok = 1'b1;
                break;
            end
            lat++;
        end
        if (!ok) check_eq("term_timeout", 32'd0, 32'd1);
    endtask

    task automatic classic(input logic [31:0] adr, input bit we, input logic [3:0] sel,
                           input logic [31:0] dat, input bit exp_err,
                           output int lat, output logic [31:0] rd);
        exp_t e;
        logic [9:0] w;
        w          = adr[11:2];
        e.is_err   = exp_err;
        e.chk_data = !we;
        e.data     = we ? 32'h0 : mem_m[w];
        sb_q.push_back(e);
        @(posedge clk); #1;
        bus.m_wb_cyc_o = 1'b1;
        bus.m_wb_stb_o = 1'b1;
        bus.m_wb_we_o  = we;
        bus.m_wb_sel_o = sel;
        bus.m_wb_adr_o = adr;
        bus.m_wb_dat_o = dat;
        bus.m_wb_cti_o = CTI_CLASSIC;
        bus.m_wb_bte_o = BTE_LINEAR;
        wait_term(lat);
        rd = bus.m_wb_dat_i;
        @(posedge clk); #1;
        bus_idle();
        if (!exp_err && we) mem_m[w] = merge(mem_m[w], dat, sel);
    endtask

    task automatic burst(input int words[8], input int n, input logic [1:0] bte, input bit we,
                         input int gap_at, output int first_lat, output int span);
        exp_t        e;
        logic [31:0] wd[8];
        int          lat, t0, t1;
        t0 = 0;
        t1 = 0;
        first_lat = 0;
        for (int b = 0; b < n; b++) begin
            wd[b]      = $urandom();
            e.is_err   = 1'b0;
            e.chk_data = !we;
            e.data     = we ? 32'h0 : mem_m[words[b]];
            sb_q.push_back(e);
        end
        @(posedge clk); #1;
        bus.m_wb_cyc_o = 1'b1;
        bus.m_wb_stb_o = 1'b1;
        bus.m_wb_we_o  = we;
        bus.m_wb_sel_o = 4'hF;
        bus.m_wb_adr_o = 32'(words[0]) << 2;
        bus.m_wb_dat_o = wd[0];
        bus.m_wb_cti_o = (n == 1) ? CTI_EOB : CTI_INCR;
        bus.m_wb_bte_o = bte;
        for (int b = 0; b < n; b++) begin
            wait_term(lat);
            if (b == 0) begin
                first_lat = lat;
                t0 = cyc_n;
            end
            t1 = cyc_n;
            @(posedge clk); #1;
            if (b + 1 < n) begin
                bus.m_wb_adr_o = 32'(words[b+1]) << 2;
                bus.m_wb_dat_o = wd[b+1];
                bus.m_wb_cti_o = (b + 2 == n) ? CTI_EOB : CTI_INCR;
                if (b == gap_at) begin
                    bus.m_wb_stb_o = 1'b0;
                    @(posedge clk); #1;
                    bus.m_wb_stb_o = 1'b1;
                end
            end
        end
        bus_idle();
        if (we)
            for (int b = 0; b < n; b++) mem_m[words[b]] = wd[b];
        span = t1 - t0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          lat, span, hits, acc_before;
        logic [31:0] rd;
        int          wl[8];

        bus_idle();
        rst        = 1'b1;
        wait_cfg   = 4'd0;
        err_inject = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ack", 32'(bus.m_wb_ack_i), 32'd0);
        check_eq("rst_err", 32'(bus.m_wb_err_i), 32'd0);
        check_eq("rst_rty", 32'(bus.m_wb_rty_i), 32'd0);
        check_eq("rst_dat", bus.m_wb_dat_i, 32'd0);
        check_eq("rst_acc", 32'(acc_cnt), 32'd0);
        rst = 1'b0;

        // 1: classic write then read, zero wait states
        classic(32'h40, 1'b1, 4'hF, 32'hDEAD_BEEF, 1'b0, lat, rd);
        check_eq("t1_wr_lat", 32'(lat), 32'd1);
        classic(32'h40, 1'b0, 4'hF, 32'h0, 1'b0, lat, rd);
        check_eq("t1_rd_lat", 32'(lat), 32'd1);
        check_eq("t1_rd", rd, 32'hDEAD_BEEF);
        check_eq("t1_acc", 32'(acc_cnt), 32'd2);

        // 2: partial byte-lane write
        classic(32'h44, 1'b1, 4'hF, 32'hFFFF_FFFF, 1'b0, lat, rd);
        classic(32'h44, 1'b1, 4'b0011, 32'h1234_5678, 1'b0, lat, rd);
        classic(32'h44, 1'b0, 4'hF, 32'h0, 1'b0, lat, rd);
        check_eq("t2_rd", rd, 32'hFFFF_5678);

        // 3: wait states, then an aborted write in WAIT
        classic(32'hC8, 1'b1, 4'hF, 32'h5A5A_0050, 1'b0, lat, rd);
        wait_cfg = 4'd3;
        classic(32'h40, 1'b0, 4'hF, 32'h0, 1'b0, lat, rd);
        check_eq("t3_wait_lat", 32'(lat), 32'd4);
        @(posedge clk); #1;
        bus.m_wb_cyc_o = 1'b1;
        bus.m_wb_stb_o = 1'b1;
        bus.m_wb_we_o  = 1'b1;
        bus.m_wb_sel_o = 4'hF;
        bus.m_wb_adr_o = 32'hC8;
        bus.m_wb_dat_o = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        bus_idle();
        hits = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.m_wb_ack_i || bus.m_wb_err_i) hits++;
        end
        check_eq("t3_abort_no_ack", 32'(hits), 32'd0);
        check_eq("t3_abort_idle", 32'(dut.r_state_q), 32'(S_IDLE));
        wait_cfg = 4'd0;
        classic(32'hC8, 1'b0, 4'hF, 32'h0, 1'b0, lat, rd);
        check_eq("t3_abort_nowrite", rd, 32'h5A5A_0050);

        // 4: wrap-4 read burst from word 6
        for (int i = 4; i < 8; i++)
            classic(32'(i) << 2, 1'b1, 4'hF, 32'hC0DE_0000 + 32'(i), 1'b0, lat, rd);
        wl = '{6, 7, 4, 5, 0, 0, 0, 0};
        burst(wl, 4, BTE_WRAP4, 1'b0, -1, lat, span);
        check_eq("t4_first_lat", 32'(lat), 32'd1);
        check_eq("t4_span", 32'(span), 32'd3);
        @(negedge clk);
        check_eq("t4_idle", 32'(dut.r_state_q), 32'(S_IDLE));

        // linear write burst words 8..15, then wrap-8 read from 13 with waits and a master gap
        wl = '{8, 9, 10, 11, 12, 13, 14, 15};
        burst(wl, 8, BTE_LINEAR, 1'b1, -1, lat, span);
        check_eq("lin_span", 32'(span), 32'd7);
        wait_cfg = 4'd2;
        wl = '{13, 14, 15, 8, 9, 0, 0, 0};
        burst(wl, 5, BTE_WRAP8, 1'b0, 1, lat, span);
        check_eq("w8_first_lat", 32'(lat), 32'd3);
        check_eq("w8_span_gap", 32'(span), 32'd5);
        wait_cfg = 4'd0;

        // 5: out-of-window and injected errors
        classic(32'h0, 1'b1, 4'hF, 32'h0BAD_F00D, 1'b0, lat, rd);
        @(negedge clk);
        acc_before = int'(acc_cnt);
        classic(32'h4000, 1'b0, 4'hF, 32'h0, 1'b1, lat, rd);
        check_eq("t5_err_lat", 32'(lat), 32'd1);
        classic(32'h4000, 1'b1, 4'hF, 32'hFFFF_FFFF, 1'b1, lat, rd);
        err_inject = 1'b1;
        classic(32'h40, 1'b1, 4'hF, 32'h0, 1'b1, lat, rd);
        err_inject = 1'b0;
        check_eq("t5_acc_hold", 32'(acc_cnt), 32'(acc_before));
        classic(32'h0, 1'b0, 4'hF, 32'h0, 1'b0, lat, rd);
        check_eq("t5_no_alias", rd, 32'h0BAD_F00D);
        classic(32'h40, 1'b0, 4'hF, 32'h0, 1'b0, lat, rd);
        check_eq("t5_inj_nowrite", rd, 32'hDEAD_BEEF);

        // 6: reset during beat 2 of an 8-beat write burst
        classic(32'd400, 1'b1, 4'hF, 32'hA0A0_0000, 1'b0, lat, rd);
        classic(32'd404, 1'b1, 4'hF, 32'hA1A1_0001, 1'b0, lat, rd);
        begin
            exp_t e;
            e.is_err = 1'b0; e.chk_data = 1'b0; e.data = 32'h0;
            sb_q.push_back(e);
            sb_q.push_back(e);
        end
        @(posedge clk); #1;
        bus.m_wb_cyc_o = 1'b1;
        bus.m_wb_stb_o = 1'b1;
        bus.m_wb_we_o  = 1'b1;
        bus.m_wb_sel_o = 4'hF;
        bus.m_wb_adr_o = 32'd400;
        bus.m_wb_dat_o = 32'hB0B0_0000;
        bus.m_wb_cti_o = CTI_INCR;
        bus.m_wb_bte_o = BTE_LINEAR;
        wait_term(lat);
        @(posedge clk); #1;
        bus.m_wb_adr_o = 32'd404;
        bus.m_wb_dat_o = 32'hB1B1_0001;
        wait_term(lat);
        check_eq("t6_beat2_ack", 32'(bus.m_wb_ack_i), 32'd1);
        #1 rst = 1'b1;
        @(negedge clk);
        check_eq("t6_rst_ack", 32'(bus.m_wb_ack_i), 32'd0);
        check_eq("t6_rst_err", 32'(bus.m_wb_err_i), 32'd0);
        check_eq("t6_rst_acc", 32'(acc_cnt), 32'd0);
        bus_idle();
        @(posedge clk); #1;
        rst = 1'b0;
        mem_m[100] = 32'hB0B0_0000;
        classic(32'd404, 1'b0, 4'hF, 32'h0, 1'b0, lat, rd);
        check_eq("t6_rd_lat", 32'(lat), 32'd1);
        check_eq("t6_beat2_nowrite", rd, 32'hA1A1_0001);
        classic(32'd400, 1'b0, 4'hF, 32'h0, 1'b0, lat, rd);
        check_eq("t6_beat1_written", rd, 32'hB0B0_0000);
        check_eq("t6_acc", 32'(acc_cnt), 32'd2);

        repeat (2) @(negedge clk);
        check_eq("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
